// File: rtl/sprite_loader_if.sv
// rtl/sprite_loader_if.sv - command byte stream between host source and sprite_loader
interface sprite_loader_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;

  // host byte source drives data/valid
  modport master (output cmd_data, output cmd_valid, input cmd_ready);
  // sprite_loader consumes bytes and returns ready
  modport slave  (input cmd_data, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/sprite_loader.sv
// rtl/sprite_loader.sv - command parser programming one 8x8 sprite object (optional SPRITE_LOADER_VSYNC_EN)
module sprite_loader (
  input  logic                  clk,
  input  logic                  rst,
  sprite_loader_if.slave        cmd,
  input  logic                  vblank,
  output logic [9:0]            new_x,
  output logic [9:0]            new_y,
  output logic                  setxy,
  output logic                  change_pxl,
  output logic [23:0]           pxl,
  output logic                  active,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE, POS_ARG, POS_WAIT, POS_SET, PIX_ARG, PIX_WR, FILL_ARG, FILL_WR
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] cnt;
  logic [5:0] idx;
  logic [9:0] pos_x, pos_y;
  logic [9:0] arg_x, arg_y;
  logic [7:0] col_r, col_g;

  logic       accept;
  logic       go_set;
  logic       go_wr;
  logic       op_err;
  logic [5:0] wr_i;
  logic [9:0] tgt_y;

  assign cmd.cmd_ready = ~rst & ((state == IDLE) || (state == POS_ARG) ||
                                 (state == PIX_ARG) || (state == FILL_ARG));
  assign busy   = (state != IDLE);
  assign accept = cmd.cmd_valid & cmd.cmd_ready;

  // y_lo is still on the bus when setxy is launched straight from POS_ARG
  assign tgt_y = (state == POS_ARG) ? {arg_y[9:8], cmd.cmd_data} : arg_y;

`ifndef SPRITE_LOADER_VSYNC_EN
  logic unused_vblank;
  assign unused_vblank = vblank;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state decode plus strobe launch controls
  always_comb begin
    state_nxt = state;
    go_set    = 1'b0;
    go_wr     = 1'b0;
    op_err    = 1'b0;
    wr_i      = idx;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd.cmd_data)
            8'h01: state_nxt = POS_ARG;
            8'h02: state_nxt = PIX_ARG;
            8'h03: state_nxt = FILL_ARG;
            8'h04, 8'h05: state_nxt = IDLE;
            default: op_err = 1'b1;
          endcase
        end
      end
      POS_ARG: begin
        if (accept && cnt == 2'd3) begin
`ifdef SPRITE_LOADER_VSYNC_EN
          state_nxt = POS_WAIT;
`else
          state_nxt = POS_SET;
          go_set    = 1'b1;
`endif
        end
      end
      POS_WAIT: begin
`ifdef SPRITE_LOADER_VSYNC_EN
        if (vblank) begin
          state_nxt = POS_SET;
          go_set    = 1'b1;
        end
`else
        state_nxt = IDLE;
`endif
      end
      POS_SET: state_nxt = IDLE;
      PIX_ARG: begin
        if (accept && cnt == 2'd2) begin
          state_nxt = PIX_WR;
          go_wr     = 1'b1;
        end
      end
      PIX_WR: state_nxt = (idx == 6'd63) ? IDLE : PIX_ARG;
      FILL_ARG: begin
        if (accept && cnt == 2'd2) begin
          state_nxt = FILL_WR;
          go_wr     = 1'b1;
        end
      end
      FILL_WR: begin
        if (idx == 6'd63) begin
          state_nxt = IDLE;
        end else begin
          go_wr = 1'b1;
          wr_i  = idx + 6'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // argument capture, position mirror and registered object-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 2'd0;
      idx        <= 6'd0;
      pos_x      <= 10'd0;
      pos_y      <= 10'd0;
      arg_x      <= 10'd0;
      arg_y      <= 10'd0;
      col_r      <= 8'd0;
      col_g      <= 8'd0;
      new_x      <= 10'd0;
      new_y      <= 10'd0;
      pxl        <= 24'd0;
      setxy      <= 1'b0;
      change_pxl <= 1'b0;
      active     <= 1'b0;
      err        <= 1'b0;
    end else begin
      setxy      <= go_set;
      change_pxl <= go_wr;
      err        <= op_err;

      if (state_nxt != state)
        cnt <= 2'd0;
      else if (accept && state != IDLE)
        cnt <= cnt + 2'd1;

      if (accept && state == POS_ARG) begin
        case (cnt)
          2'd0: arg_x[9:8] <= cmd.cmd_data[1:0];
          2'd1: arg_x[7:0] <= cmd.cmd_data;
          2'd2: arg_y[9:8] <= cmd.cmd_data[1:0];
          default: arg_y[7:0] <= cmd.cmd_data;
        endcase
      end

      if (accept && (state == PIX_ARG || state == FILL_ARG)) begin
        if (cnt == 2'd0) col_r <= cmd.cmd_data;
        if (cnt == 2'd1) col_g <= cmd.cmd_data;
      end

      if (accept && state == IDLE) begin
        if (cmd.cmd_data == 8'h04) active <= 1'b1;
        if (cmd.cmd_data == 8'h05) active <= 1'b0;
      end

      if (state == IDLE)
        idx <= 6'd0;
      else if (state == PIX_WR || state == FILL_WR)
        idx <= idx + 6'd1;

      if (go_set) begin
        pos_x <= arg_x;
        pos_y <= tgt_y;
        new_x <= arg_x;
        new_y <= tgt_y;
      end else if (go_wr) begin
        new_x <= pos_x + {7'd0, wr_i[2:0]};
        new_y <= pos_y + {7'd0, wr_i[5:3]};
        if (state != FILL_WR)
          pxl <= {col_r, col_g, cmd.cmd_data};
      end
    end
  end

endmodule

// File: tb/tb_sprite_loader.sv
// tb/tb_sprite_loader.sv - scoreboard bench for sprite_loader (SPRITE_LOADER_VSYNC_EN aware)
module tb_sprite_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vblank = 1'b0;
  logic [9:0]  new_x, new_y;
  logic        setxy, change_pxl, active, busy, err;
  logic [23:0] pxl;

  sprite_loader_if cmd_if ();

  sprite_loader dut (
    .clk(clk), .rst(rst), .cmd(cmd_if), .vblank(vblank),
    .new_x(new_x), .new_y(new_y), .setxy(setxy), .change_pxl(change_pxl),
    .pxl(pxl), .active(active), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 setxy, 1 pixel write, 2 err
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] p;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  m_px = 0, m_py = 0;
  bit  m_active = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_ev(input int kind, input int x, input int y, input logic [23:0] p);
    ev_t e;
    e.kind = kind;
    e.x = 10'(x % 1024);
    e.y = 10'(y % 1024);
    e.p = p;
    exp_q.push_back(e);
  endtask

  // monitor: every strobe must match the oldest expected event
  always @(negedge clk) begin
    ev_t e;
    int  k;
    if (!rst && (setxy || change_pxl || err)) begin
      if (setxy && change_pxl) check("setxy_pxl_overlap", 1'b1, 1'b0);
      k = setxy ? 0 : (change_pxl ? 1 : 2);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {61'd0, setxy, change_pxl, err}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", k, e.kind);
        if (k == 0) begin
          check("setxy_x", new_x, e.x);
          check("setxy_y", new_y, e.y);
        end else if (k == 1) begin
          check("pix_x", new_x, e.x);
          check("pix_y", new_y, e.y);
          check("pix_data", pxl, e.p);
          check("pix_ready_low", cmd_if.cmd_ready, 1'b0);
          check("pix_busy", busy, 1'b1);
        end else begin
          check("err_busy", busy, 1'b0);
        end
      end
    end
  end

  // drives one byte; returns one time unit after the accepting edge
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      cmd_if.cmd_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    cmd_if.cmd_data  = b;
    cmd_if.cmd_valid = 1'b1;
    n = 0;
    while (!cmd_if.cmd_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_if.cmd_ready) begin
      check("accept_timeout", cmd_if.cmd_ready, 1'b1);
      cmd_if.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic set_pos(input logic [7:0] xh, input logic [7:0] xl,
                         input logic [7:0] yh, input logic [7:0] yl);
    int nx, ny;
    nx = {xh[1:0], xl};
    ny = {yh[1:0], yl};
    push_ev(0, nx, ny, 24'd0);
`ifdef SPRITE_LOADER_VSYNC_EN
    vblank = 1'b1;
`else
    vblank = 1'($urandom_range(0, 1));
`endif
    send(8'h01, 0);
    send(xh, 0);
    send(xl, 0);
    send(yh, 0);
    send(yl, 0);
`ifdef SPRITE_LOADER_VSYNC_EN
    check("setxy_wait_cycle", setxy, 1'b0);
    @(posedge clk); #1;
`endif
    check("setxy_timing", setxy, 1'b1);
    check("setxy_ready_low", cmd_if.cmd_ready, 1'b0);
    m_px = nx;
    m_py = ny;
  endtask

  task automatic load(input bit rnd, input int gapmax, input int npix);
    logic [7:0]  iv;
    logic [23:0] p;
    for (int i = 0; i < npix; i++) begin
      iv = 8'(i);
      p  = rnd ? 24'($urandom) : {iv, ~iv, 8'h55};
      push_ev(1, m_px + i % 8, m_py + i / 8, p);
      if (i == 0) send(8'h02, $urandom_range(0, gapmax));
      send(p[23:16], $urandom_range(0, gapmax));
      send(p[15:8],  $urandom_range(0, gapmax));
      send(p[7:0],   $urandom_range(0, gapmax));
      check("load_strobe_after_b", change_pxl, 1'b1);
      check("load_ready_low", cmd_if.cmd_ready, 1'b0);
    end
    if (npix == 64) begin
      @(posedge clk); #1;
      check("load_busy_drop", busy, 1'b0);
    end
  endtask

  task automatic fill(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int bad;
    for (int k = 0; k < 64; k++) push_ev(1, m_px + k % 8, m_py + k / 8, {r, g, b});
    send(8'h03, 0);
    send(r, $urandom_range(0, 2));
    send(g, $urandom_range(0, 2));
    send(b, $urandom_range(0, 2));
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (!(change_pxl === 1'b1 && cmd_if.cmd_ready === 1'b0)) bad++;
      @(posedge clk); #1;
    end
    check("fill_burst_violations", bad, 0);
    check("fill_end_strobe", change_pxl, 1'b0);
    check("fill_end_ready", cmd_if.cmd_ready, 1'b1);
  endtask

  task automatic show_hide(input bit on);
    send(on ? 8'h04 : 8'h05, 0);
    m_active = on;
    check("active_level", active, m_active);
  endtask

  task automatic bad_op(input logic [7:0] op);
    push_ev(2, 0, 0, 24'd0);
    send(op, 0);
    check("err_pulse", err, 1'b1);
    check("err_idle_ready", cmd_if.cmd_ready, 1'b1);
    @(posedge clk); #1;
    check("err_one_cycle", err, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int strb, bad;
    logic [7:0] op;
    cmd_if.cmd_data  = 8'h00;
    cmd_if.cmd_valid = 1'b0;

    #2;
    check("reset_outputs", {new_x, new_y, pxl, setxy, change_pxl, active, busy, err}, 64'd0);
    check("reset_ready", cmd_if.cmd_ready, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", cmd_if.cmd_ready, 1'b1);

    set_pos(8'h01, 8'h3C, 8'h00, 8'hF0);
    load(1'b0, 0, 64);
    fill(8'hFF, 8'h00, 8'h00);
    show_hide(1'b1);
    show_hide(1'b0);
    bad_op(8'h7E);
    show_hide(1'b1);

    // randomized command mix
    for (int it = 0; it < 14; it++) begin
      case ($urandom_range(0, 5))
        0: set_pos(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        1: fill(8'($urandom), 8'($urandom), 8'($urandom));
        2: load(1'b1, 2, 64);
        3: show_hide(1'($urandom_range(0, 1)));
        4: begin
          op = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(6, 255));
          bad_op(op);
        end
        default: set_pos(8'hFF, 8'hFF, 8'hFE, 8'h80);
      endcase
    end

`ifdef SPRITE_LOADER_VSYNC_EN
    vblank = 1'b0;
    push_ev(0, 10'h155, 10'h0AA, 24'd0);
    send(8'h01, 0); send(8'h01, 0); send(8'h55, 0); send(8'h00, 0); send(8'hAA, 0);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      if (setxy !== 1'b0 || cmd_if.cmd_ready !== 1'b0 || busy !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    check("vsync_hold_violations", bad, 0);
    vblank = 1'b1;
    @(posedge clk); #1;
    check("vsync_setxy", setxy, 1'b1);
    m_px = 10'h155;
    m_py = 10'h0AA;
    vblank = 1'b0;
`endif

    // reset in the middle of a gapped LOAD
    set_pos(8'h00, 8'h20, 8'h00, 8'h30);
    show_hide(1'b1);
    load(1'b0, 3, 30);
    @(posedge clk); #1;
    check("queue_before_reset", exp_q.size(), 0);
    rst = 1'b1;
    #1;
    check("midreset_outputs", {new_x, new_y, pxl, setxy, change_pxl, active, busy, err}, 64'd0);
    check("midreset_ready", cmd_if.cmd_ready, 1'b0);
    m_px = 0;
    m_py = 0;
    m_active = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    strb = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (setxy || change_pxl || err) strb++;
    end
    check("strobes_after_reset", strb, 0);
    check("busy_after_reset", busy, 1'b0);
    @(posedge clk); #1;
    fill(8'h12, 8'h34, 8'h56);
    set_pos(8'h03, 8'hFC, 8'h03, 8'hFE);
    load(1'b1, 1, 64);

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
